// File: rtl/esm_issue_ctrl.sv
// Issue-side controller for the ESM instruction buffer: owns slot allocation, waits for each new
// entry's dependency row to settle, and issues independent entries over a valid/ready handshake.
module esm_issue_ctrl #(
    parameter int unsigned bs            = 16,
    parameter int unsigned settle_cycles = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_req,
    output logic                  alloc_gnt,
    output logic [$clog2(bs)-1:0] buffer_index,
    output logic [0:bs-1]         valid_entries,
    input  logic [0:bs-1]         independent_instr,
    output logic                  issue_valid,
    output logic [$clog2(bs)-1:0] issue_index,
    input  logic                  issue_ready,
    input  logic                  complete_valid,
    input  logic [$clog2(bs)-1:0] complete_index,
    output logic                  illegal_complete
);

    localparam int unsigned IdxW = $clog2(bs);
    localparam int unsigned CntW = $clog2(settle_cycles + 1);

    typedef enum logic [1:0] {StFree, StSettle, StReady, StIssued} entry_state_e;

    entry_state_e    state_q [bs];
    entry_state_e    state_d [bs];
    logic [CntW-1:0] cnt_q   [bs];
    logic [CntW-1:0] cnt_d   [bs];

    logic [IdxW-1:0] rr_q, rr_d;
    logic            issue_valid_q, issue_valid_d;
    logic [IdxW-1:0] issue_index_q, issue_index_d;
    logic            illegal_q, illegal_d;

    logic            any_free;
    logic [IdxW-1:0] free_idx;
    logic            transfer;
    logic [bs-1:0]   eligible;
    logic [IdxW-1:0] search_start;
    logic [IdxW-1:0] cand;
    logic            sel_found;
    logic [IdxW-1:0] sel_idx;

    assign transfer = issue_valid_q & issue_ready;

    // Lowest-numbered free slot; scanning downwards leaves the lowest one last.
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int i = int'(bs) - 1; i >= 0; i--) begin
            if (state_q[i] == StFree) begin
                any_free = 1'b1;
                free_idx = IdxW'(i);
            end
        end
    end

    assign alloc_gnt    = alloc_req & any_free;
    assign buffer_index = free_idx;

    // The entry leaving on this cycle's transfer must not be re-selected.
    always_comb begin
        for (int i = 0; i < int'(bs); i++) begin
            eligible[i] = (state_q[i] == StReady) && independent_instr[i];
        end
        if (transfer) begin
            eligible[issue_index_q] = 1'b0;
        end
    end

    always_comb begin
        search_start = transfer ? issue_index_q + 1'b1 : rr_q;
        sel_found    = 1'b0;
        sel_idx      = '0;
        cand         = '0;
        for (int k = 0; k < int'(bs); k++) begin
            cand = search_start + IdxW'(k);
            if (!sel_found && eligible[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        issue_valid_d = issue_valid_q;
        issue_index_d = issue_index_q;
        rr_d          = rr_q;
        // An offer stays put until it is taken.
        if (!issue_valid_q || transfer) begin
            issue_valid_d = sel_found;
            if (sel_found) begin
                issue_index_d = sel_idx;
            end
        end
        if (transfer) begin
            rr_d = issue_index_q + 1'b1;
        end
        illegal_d = illegal_q |
                    (complete_valid && (state_q[complete_index] != StIssued));
    end

    always_comb begin
        for (int i = 0; i < int'(bs); i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                StFree: begin
                    if (alloc_gnt && (free_idx == IdxW'(i))) begin
                        state_d[i] = StSettle;
                        cnt_d[i]   = CntW'(settle_cycles);
                    end
                end
                StSettle: begin
                    if (cnt_q[i] <= CntW'(1)) begin
                        state_d[i] = StReady;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] - 1'b1;
                    end
                end
                StReady: begin
                    if (transfer && (issue_index_q == IdxW'(i))) begin
                        state_d[i] = StIssued;
                    end
                end
                StIssued: begin
                    if (complete_valid && (complete_index == IdxW'(i))) begin
                        state_d[i] = StFree;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(bs); i++) begin
                state_q[i] <= StFree;
                cnt_q[i]   <= '0;
            end
            rr_q          <= '0;
            issue_valid_q <= 1'b0;
            issue_index_q <= '0;
            illegal_q     <= 1'b0;
        end else begin
            for (int i = 0; i < int'(bs); i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            rr_q          <= rr_d;
            issue_valid_q <= issue_valid_d;
            issue_index_q <= issue_index_d;
            illegal_q     <= illegal_d;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(bs); i++) begin
            valid_entries[i] = (state_q[i] != StFree);
        end
    end

    assign issue_valid      = issue_valid_q;
    assign issue_index      = issue_index_q;
    assign illegal_complete = illegal_q;

endmodule

// File: tb/tb_esm_issue_ctrl.sv
// Self-checking bench for esm_issue_ctrl: a table of directed vectors, hand sequences for the
// multi-cycle corners, and randomized traffic against a timestamp-based reference model.
module tb_esm_issue_ctrl;

    localparam int unsigned BS     = 16;
    localparam int unsigned SETTLE = 2;

    typedef struct {
        logic        areq;
        logic        cv;
        logic [3:0]  ci;
        logic        gnt;
        logic [3:0]  bidx;
        logic [0:15] ve;
        logic        iv;
        logic [3:0]  ii;
        logic        ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        alloc_req;
    logic        alloc_gnt;
    logic [3:0]  buffer_index;
    logic [0:15] valid_entries;
    logic [0:15] independent_instr;
    logic        issue_valid;
    logic [3:0]  issue_index;
    logic        issue_ready;
    logic        complete_valid;
    logic [3:0]  complete_index;
    logic        illegal_complete;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: occupancy, issued flag and the cycle from which each slot may be offered.
    bit m_occ [BS];
    bit m_iss [BS];
    int m_rdy [BS];
    int m_rr;
    bit m_iv;
    int m_ii;
    bit m_ill;
    int cyc = 0;

    vec_t tbl [13];
    int   got [$];
    int   iss [$];

    always #5 clk = ~clk;

    esm_issue_ctrl #(
        .bs            (BS),
        .settle_cycles (SETTLE)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .alloc_req         (alloc_req),
        .alloc_gnt         (alloc_gnt),
        .buffer_index      (buffer_index),
        .valid_entries     (valid_entries),
        .independent_instr (independent_instr),
        .issue_valid       (issue_valid),
        .issue_index       (issue_index),
        .issue_ready       (issue_ready),
        .complete_valid    (complete_valid),
        .complete_index    (complete_index),
        .illegal_complete  (illegal_complete)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h, required %0h (cycle %0d, t=%0t)",
                     name, act, exp, cyc, $time);
        end
    endtask

    function automatic vec_t mk(logic areq, logic cv, logic [3:0] ci, logic gnt,
                                logic [3:0] bidx, logic [0:15] ve, logic iv, logic [3:0] ii,
                                logic ill);
        vec_t v;
        v.areq = areq; v.cv = cv; v.ci = ci; v.gnt = gnt; v.bidx = bidx;
        v.ve = ve; v.iv = iv; v.ii = ii; v.ill = ill;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < BS; i++) begin
            m_occ[i] = 1'b0;
            m_iss[i] = 1'b0;
            m_rdy[i] = 0;
        end
        m_rr  = 0;
        m_iv  = 1'b0;
        m_ii  = 0;
        m_ill = 1'b0;
    endtask

    function automatic int lowest_free();
        int fi = -1;
        for (int i = int'(BS) - 1; i >= 0; i--) begin
            if (!m_occ[i]) fi = i;
        end
        return fi;
    endfunction

    task automatic check_outputs();
        logic [0:15] exp_ve;
        int fi;
        fi = lowest_free();
        for (int i = 0; i < BS; i++) exp_ve[i] = m_occ[i];
        chk("model alloc_gnt", 32'(alloc_gnt), 32'(alloc_req && (fi >= 0)));
        chk("model buffer_index", 32'(buffer_index), 32'((fi >= 0) ? fi : 0));
        chk("model valid_entries", 32'(valid_entries), 32'(exp_ve));
        chk("model issue_valid", 32'(issue_valid), 32'(m_iv));
        if (m_iv) chk("model issue_index", 32'(issue_index), 32'(m_ii));
        chk("model illegal_complete", 32'(illegal_complete), 32'(m_ill));
    endtask

    task automatic model_step();
        bit xfer;
        bit elig [BS];
        bit found;
        int fi, start, idx, sel, old_ii, ci;
        xfer   = m_iv && issue_ready;
        old_ii = m_ii;
        fi     = lowest_free();
        for (int i = 0; i < BS; i++) begin
            elig[i] = m_occ[i] && !m_iss[i] && (cyc >= m_rdy[i]) && independent_instr[i];
        end
        if (xfer) elig[old_ii] = 1'b0;
        if (complete_valid) begin
            ci = int'(complete_index);
            if (m_occ[ci] && m_iss[ci]) begin
                m_occ[ci] = 1'b0;
                m_iss[ci] = 1'b0;
            end else begin
                m_ill = 1'b1;
            end
        end
        if (!m_iv || xfer) begin
            start = xfer ? (old_ii + 1) % BS : m_rr;
            found = 1'b0;
            sel   = 0;
            for (int k = 0; k < BS; k++) begin
                idx = (start + k) % BS;
                if (!found && elig[idx]) begin
                    found = 1'b1;
                    sel   = idx;
                end
            end
            m_iv = found;
            if (found) m_ii = sel;
        end
        if (xfer) begin
            m_iss[old_ii] = 1'b1;
            m_rr = (old_ii + 1) % BS;
        end
        if (alloc_req && (fi >= 0)) begin
            m_occ[fi] = 1'b1;
            m_iss[fi] = 1'b0;
            m_rdy[fi] = cyc + 1 + SETTLE;
        end
        cyc++;
    endtask

    task automatic probe();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        probe();
        advance();
    endtask

    task automatic do_reset();
        rst               = 1'b0;
        alloc_req         = 1'b0;
        issue_ready       = 1'b0;
        complete_valid    = 1'b0;
        complete_index    = '0;
        independent_instr = '1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = mk(1'b1, 1'b0, 4'd0, 1'b1, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0);
        tbl[1]  = mk(1'b1, 1'b0, 4'd0, 1'b1, 4'd1, 16'h8000, 1'b0, 4'd0, 1'b0);
        tbl[2]  = mk(1'b1, 1'b0, 4'd0, 1'b1, 4'd2, 16'hC000, 1'b0, 4'd0, 1'b0);
        tbl[3]  = mk(1'b0, 1'b0, 4'd0, 1'b0, 4'd3, 16'hE000, 1'b0, 4'd0, 1'b0);
        tbl[4]  = mk(1'b0, 1'b0, 4'd0, 1'b0, 4'd3, 16'hE000, 1'b1, 4'd0, 1'b0);
        tbl[5]  = mk(1'b0, 1'b0, 4'd0, 1'b0, 4'd3, 16'hE000, 1'b1, 4'd1, 1'b0);
        tbl[6]  = mk(1'b0, 1'b0, 4'd0, 1'b0, 4'd3, 16'hE000, 1'b1, 4'd2, 1'b0);
        tbl[7]  = mk(1'b0, 1'b1, 4'd0, 1'b0, 4'd3, 16'hE000, 1'b0, 4'd0, 1'b0);
        tbl[8]  = mk(1'b0, 1'b1, 4'd1, 1'b0, 4'd0, 16'h6000, 1'b0, 4'd0, 1'b0);
        tbl[9]  = mk(1'b0, 1'b1, 4'd2, 1'b0, 4'd0, 16'h2000, 1'b0, 4'd0, 1'b0);
        tbl[10] = mk(1'b0, 1'b1, 4'd3, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0);
        tbl[11] = mk(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b1);
        tbl[12] = mk(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b1);

        // Reset, allocate three, issue 0/1/2, complete them, then complete free slot 3.
        do_reset();
        for (int r = 0; r < 13; r++) begin
            alloc_req         = tbl[r].areq;
            complete_valid    = tbl[r].cv;
            complete_index    = tbl[r].ci;
            issue_ready       = 1'b1;
            independent_instr = '1;
            probe();
            chk("tbl alloc_gnt", 32'(alloc_gnt), 32'(tbl[r].gnt));
            chk("tbl buffer_index", 32'(buffer_index), 32'(tbl[r].bidx));
            chk("tbl valid_entries", 32'(valid_entries), 32'(tbl[r].ve));
            chk("tbl issue_valid", 32'(issue_valid), 32'(tbl[r].iv));
            if (tbl[r].iv) chk("tbl issue_index", 32'(issue_index), 32'(tbl[r].ii));
            chk("tbl illegal_complete", 32'(illegal_complete), 32'(tbl[r].ill));
            advance();
        end

        // Dependency hold: slot 1 not offered until its independent bit rises.
        do_reset();
        issue_ready = 1'b1;
        independent_instr = '1;
        independent_instr[1] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            alloc_req = (c < 2);
            probe();
            chk("dep slot1 held", 32'(issue_valid && (issue_index == 4'd1)), 32'd0);
            if (c == 4) begin
                chk("dep slot0 valid", 32'(issue_valid), 32'd1);
                chk("dep slot0 index", 32'(issue_index), 32'd0);
            end
            advance();
        end
        alloc_req = 1'b0;
        independent_instr[1] = 1'b1;
        tick();
        probe();
        chk("dep slot1 valid", 32'(issue_valid), 32'd1);
        chk("dep slot1 index", 32'(issue_index), 32'd1);
        advance();

        // Backpressure: offer of slot 0 holds while slot 1 becomes eligible.
        do_reset();
        independent_instr = '1;
        for (int c = 0; c < 9; c++) begin
            alloc_req = (c < 2);
            issue_ready = 1'b0;
            probe();
            if (c >= 4) begin
                chk("bp hold valid", 32'(issue_valid), 32'd1);
                chk("bp hold index", 32'(issue_index), 32'd0);
            end
            advance();
        end
        issue_ready = 1'b1;
        probe();
        chk("bp xfer index", 32'(issue_index), 32'd0);
        advance();
        issue_ready = 1'b0;
        probe();
        chk("bp next valid", 32'(issue_valid), 32'd1);
        chk("bp next index", 32'(issue_index), 32'd1);
        advance();

        // Full buffer: only slot 7 issues; completing it frees exactly that slot.
        do_reset();
        independent_instr = '0;
        independent_instr[7] = 1'b1;
        issue_ready = 1'b1;
        for (int c = 0; c < 18; c++) begin
            alloc_req = 1'b1;
            complete_valid = (c == 16);
            complete_index = 4'd7;
            probe();
            if (c == 16) begin
                chk("full gnt", 32'(alloc_gnt), 32'd0);
                chk("full bidx", 32'(buffer_index), 32'd0);
            end
            if (c == 17) begin
                chk("refill gnt", 32'(alloc_gnt), 32'd1);
                chk("refill bidx", 32'(buffer_index), 32'd7);
            end
            advance();
        end
        complete_valid = 1'b0;

        // Round-robin: all 16 become eligible together and issue in order 0..15.
        do_reset();
        independent_instr = '0;
        issue_ready = 1'b1;
        for (int c = 0; c < 21; c++) begin
            alloc_req = (c < 16);
            tick();
        end
        alloc_req = 1'b0;
        independent_instr = '1;
        got.delete();
        for (int c = 0; c < 40 && got.size() < 16; c++) begin
            probe();
            if (issue_valid && issue_ready) got.push_back(int'(issue_index));
            advance();
        end
        chk("rr count", 32'(got.size()), 32'd16);
        foreach (got[k]) chk("rr order", 32'(got[k]), 32'(k));

        // Pointer wraps past 15: slots 14 then 2 refilled; 14 goes first, then search wraps to 2.
        complete_valid = 1'b1;
        complete_index = 4'd14;
        tick();
        complete_index = 4'd2;
        alloc_req = 1'b1;
        tick();
        complete_valid = 1'b0;
        tick();
        alloc_req = 1'b0;
        got.delete();
        for (int c = 0; c < 15 && got.size() < 2; c++) begin
            probe();
            if (issue_valid && issue_ready) got.push_back(int'(issue_index));
            advance();
        end
        chk("wrap count", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            chk("wrap first", 32'(got[0]), 32'd14);
            chk("wrap second", 32'(got[1]), 32'd2);
        end

        // Complete slot 2 twice: the second is illegal and sticks.
        complete_valid = 1'b1;
        complete_index = 4'd2;
        tick();
        tick();
        complete_valid = 1'b0;
        tick();
        probe();
        chk("illegal sticky", 32'(illegal_complete), 32'd1);
        advance();

        // Reset mid-operation: outputs return to reset values within the same cycle.
        alloc_req = 1'b1;
        issue_ready = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst alloc_gnt", 32'(alloc_gnt), 32'd1);
        chk("rst buffer_index", 32'(buffer_index), 32'd0);
        chk("rst valid_entries", 32'(valid_entries), 32'd0);
        chk("rst issue_valid", 32'(issue_valid), 32'd0);
        chk("rst issue_index", 32'(issue_index), 32'd0);
        chk("rst illegal", 32'(illegal_complete), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        alloc_req = 1'b0;
        tick();

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset();
            alloc_req   = ($urandom_range(3) != 0);
            issue_ready = ($urandom_range(2) != 0);
            if ($urandom_range(7) == 0) begin
                independent_instr = 16'($urandom) | 16'($urandom);
            end
            iss.delete();
            for (int i = 0; i < BS; i++) if (m_iss[i]) iss.push_back(i);
            complete_valid = 1'b0;
            complete_index = 4'($urandom_range(15));
            if (iss.size() > 0 && $urandom_range(1) == 1) begin
                complete_valid = 1'b1;
                complete_index = 4'(iss[$urandom_range(iss.size() - 1)]);
            end else if ($urandom_range(99) == 0) begin
                complete_valid = 1'b1;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
